bcd_digit_entry: RTL

- Sits directly downstream of the decimal-to-BCD key encoder.
- Consumes the encoder's 4-bit BCD code plus its key-active line, and the sign/clear/enter key lines.
- Debounces key presses and shifts accepted digits into a signed 3-digit BCD operand register.
- On ENTER, presents one signed operand, with a single-cycle valid strobe, to the adder/subtractor datapath.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_entry_key_debounce.sv | 98 +++++++++
 rtl/bcd_digit_entry.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD operand entry slice.
// Holds the digit type, BCD limits and the key debounce FSM states.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } db_state_e;

endpackage

// File: rtl/bcd_digit_entry_key_debounce.sv
// Key synchronizers and press/release debounce FSM.
// Ports: clk_i, rst_ni (sync, active-low), raw key lines in;
// commit_o (one-cycle, combinational from registered state) and the
// synchronized key snapshot (bcd_o, act_o, sign_o, clr_o, ent_o) out.
module key_debounce
    import bcd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  bcd_digit_t key_bcd_i,
    input  logic       key_act_i,
    input  logic       sign_key_i,
    input  logic       clr_key_i,
    input  logic       ent_key_i,
    output logic       commit_o,
    output bcd_digit_t bcd_o,
    output logic       act_o,
    output logic       sign_o,
    output logic       clr_o,
    output logic       ent_o
);

    // key line order: {ent, clr, sign, act}
    logic [3:0] k1_q, k2_q;
    bcd_digit_t b1_q, b2_q;
    db_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       any_key;
    logic       done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            k1_q    <= '0;
            k2_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            k1_q    <= {ent_key_i, clr_key_i, sign_key_i, key_act_i};
            k2_q    <= k1_q;
            b1_q    <= key_bcd_i;
            b2_q    <= b1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign any_key = |k2_q;
    // Counter is 0 in IDLE/HELD, so this also covers DEBOUNCE_CYCLES=1
    assign done    = ({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_CYCLES);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_PRESS_DB: begin
                if (!any_key) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d  = ST_HELD;
                    cnt_d    = '0;
                    commit_o = 1'b1;
                end else begin
                    state_d = ST_PRESS_DB;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_HELD, ST_RELEASE_DB: begin
                if (any_key) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bcd_o  = b2_q;
    assign act_o  = k2_q[0];
    assign sign_o = k2_q[1];
    assign clr_o  = k2_q[2];
    assign ent_o  = k2_q[3];

endmodule

// File: rtl/bcd_digit_entry.sv
// Signed 3-digit BCD operand entry: debounced keys build an operand.
// Ports: clk, rst_n (sync, active-low), key_bcd/key_act/sign_key/
// clr_key/ent_key in; entry_*, digit_cnt, op_*, op_valid, err out.
module bcd_digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int          NUM_DIGITS      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key_bcd,
    input  logic                    key_act,
    input  logic                    sign_key,
    input  logic                    clr_key,
    input  logic                    ent_key,
    output logic [NUM_DIGITS*4-1:0] entry_digits,
    output logic                    entry_sign,
    output logic [1:0]              digit_cnt,
    output logic [NUM_DIGITS*4-1:0] op_digits,
    output logic                    op_sign,
    output logic                    op_valid,
    output logic                    err
);

    import bcd_pkg::*;

    localparam int W = NUM_DIGITS * 4;

    logic         commit;
    bcd_digit_t   s_bcd;
    logic         s_act, s_sign, s_clr, s_ent;

    logic [W-1:0] ed_q, ed_d, od_q, od_d;
    logic         es_q, es_d, os_q, os_d;
    logic [1:0]   dc_q, dc_d;
    logic         ov_q, ov_d, er_q, er_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .key_bcd_i (key_bcd),
        .key_act_i (key_act),
        .sign_key_i(sign_key),
        .clr_key_i (clr_key),
        .ent_key_i (ent_key),
        .commit_o  (commit),
        .bcd_o     (s_bcd),
        .act_o     (s_act),
        .sign_o    (s_sign),
        .clr_o     (s_clr),
        .ent_o     (s_ent)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ed_q <= '0;
            es_q <= 1'b0;
            dc_q <= '0;
            od_q <= '0;
            os_q <= 1'b0;
            ov_q <= 1'b0;
            er_q <= 1'b0;
        end else begin
            ed_q <= ed_d;
            es_q <= es_d;
            dc_q <= dc_d;
            od_q <= od_d;
            os_q <= os_d;
            ov_q <= ov_d;
            er_q <= er_d;
        end
    end

    // Action priority: clear > enter > sign > digit
    always_comb begin
        ed_d = ed_q;
        es_d = es_q;
        dc_d = dc_q;
        od_d = od_q;
        os_d = os_q;
        ov_d = 1'b0;
        er_d = 1'b0;
        if (commit) begin
            if (s_clr) begin
                ed_d = '0;
                es_d = 1'b0;
                dc_d = '0;
            end else if (s_ent) begin
                od_d = ed_q;
                // a typed -000 goes out as +000
                os_d = es_q && (ed_q != '0);
                ov_d = 1'b1;
                ed_d = '0;
                es_d = 1'b0;
                dc_d = '0;
            end else if (s_sign) begin
                es_d = !es_q;
            end else if (s_act) begin
                if (s_bcd > BCD_MAX) begin
                    er_d = 1'b1;
                end else if (dc_q == 2'(NUM_DIGITS)) begin
                    er_d = 1'b1;
                end else begin
                    ed_d = {ed_q[W-5:0], s_bcd};
                    dc_d = dc_q + 2'd1;
                end
            end
        end
    end

    assign entry_digits = ed_q;
    assign entry_sign   = es_q;
    assign digit_cnt    = dc_q;
    assign op_digits    = od_q;
    assign op_sign      = os_q;
    assign op_valid     = ov_q;
    assign err          = er_q;

endmodule
